// File: rtl/muldiv_wb_arbiter_pkg.sv
// Shared types and constants for the mult FU writeback arbiter.
package muldiv_wb_arbiter_pkg;

  // Core configuration stand-ins; these values stand in for the CVA6 config.
  localparam int unsigned XLEN           = 64;
  localparam int unsigned TRANS_ID_BITS  = 5;
  localparam int unsigned NUM_THREADS    = 2;
  localparam int unsigned THREAD_ID_BITS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  // Bit whose value is replicated into the upper half for *W results.
  localparam int unsigned WORD_SEXT_BIT = 31;

  // One writeback record: used for the hold register and the output mux.
  typedef struct packed {
    logic [XLEN-1:0]           result;
    logic [TRANS_ID_BITS-1:0]  trans_id;
    logic [THREAD_ID_BITS-1:0] thread_id;
  } muldiv_wb_t;

  // Holding register occupancy.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/muldiv_wb_arbiter_word_sext.sv
// Combinational RV64 word-op sign extender; passes data through otherwise.
module muldiv_wb_arbiter_word_sext
  import muldiv_wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             word_op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (WIDTH == 64) begin : g_rv64
    // Replicate bit 31 into the upper word for *W operations.
    always_comb begin
      if (word_op_i) begin
        data_o = {{(WIDTH-WORD_SEXT_BIT-1){data_i[WORD_SEXT_BIT]}}, data_i[WORD_SEXT_BIT:0]};
      end else begin
        data_o = data_i;
      end
    end
  end else begin : g_pass
    assign data_o = data_i;
  end

endmodule

// File: rtl/muldiv_wb_arbiter.sv
// Merges the serial divider and pipelined multiplier result streams onto the
// single mult FU writeback port. Divider results park in a one-entry hold
// register so the divider can go idle at once; the multiplier always wins.
module muldiv_wb_arbiter
  import muldiv_wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      div_issue_i,
  input  logic                      div_word_op_i,
  input  logic                      div_valid_i,
  output logic                      div_ready_o,
  input  logic [WIDTH-1:0]          div_result_i,
  input  logic [TRANS_ID_BITS-1:0]  div_trans_id_i,
  input  logic [THREAD_ID_BITS-1:0] div_thread_id_i,
  input  logic                      mul_valid_i,
  input  logic [WIDTH-1:0]          mul_result_i,
  input  logic [TRANS_ID_BITS-1:0]  mul_trans_id_i,
  input  logic [THREAD_ID_BITS-1:0] mul_thread_id_i,
  output logic                      result_valid_o,
  output logic [WIDTH-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0]  trans_id_o,
  output logic [THREAD_ID_BITS-1:0] thread_id_o,
  output logic                      div_busy_o
);

  hold_state_e      state_q, state_d;
  muldiv_wb_t       hold_q, hold_d;
  logic             word_op_q, word_op_d;
  logic             pending_q, pending_d;
  logic             hold_valid_s;
  logic             hold_sel_s;
  logic             capture_s;
  logic [WIDTH-1:0] ext_s;

  assign hold_valid_s = (state_q == HOLD_FULL);
  // Hold entry drains only when the multiplier is silent and no flush kills it.
  assign hold_sel_s   = hold_valid_s & ~mul_valid_i & ~flush_i;
  // Free slot, or the slot empties this cycle; flush drops whatever arrives.
  assign div_ready_o  = flush_i | ~hold_valid_s | ~mul_valid_i;
  assign capture_s    = div_valid_i & div_ready_o & ~flush_i;
  assign div_busy_o   = pending_q | hold_valid_s;

  muldiv_wb_arbiter_word_sext #(
    .WIDTH (WIDTH)
  ) u_word_sext (
    .word_op_i (word_op_q),
    .data_i    (div_result_i),
    .data_o    (ext_s)
  );

  // Next-state logic for hold occupancy, hold payload, issue tracking.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    word_op_d = word_op_q;
    pending_d = pending_q;
    if (flush_i) begin
      state_d   = HOLD_EMPTY;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        HOLD_EMPTY: begin
          if (capture_s) begin
            state_d = HOLD_FULL;
          end else begin
            state_d = HOLD_EMPTY;
          end
        end
        HOLD_FULL: begin
          if (capture_s) begin
            state_d = HOLD_FULL;
          end else if (hold_sel_s) begin
            state_d = HOLD_EMPTY;
          end else begin
            state_d = HOLD_FULL;
          end
        end
        default: state_d = HOLD_EMPTY;
      endcase
      if (capture_s) begin
        hold_d.result    = XLEN'(ext_s);
        hold_d.trans_id  = div_trans_id_i;
        hold_d.thread_id = div_thread_id_i;
      end else begin
        hold_d = hold_q;
      end
      // A new issue outranks the writeback of the previous division.
      if (div_issue_i) begin
        pending_d = 1'b1;
        word_op_d = div_word_op_i;
      end else if (hold_sel_s) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= HOLD_EMPTY;
      hold_q    <= '0;
      word_op_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      word_op_q <= word_op_d;
      pending_q <= pending_d;
    end
  end

  // Output mux: multiplier first, then the hold entry, else idle zeros.
  always_comb begin
    result_valid_o = 1'b0;
    result_o       = '0;
    trans_id_o     = '0;
    thread_id_o    = '0;
    if (mul_valid_i) begin
      result_valid_o = 1'b1;
      result_o       = mul_result_i;
      trans_id_o     = mul_trans_id_i;
      thread_id_o    = mul_thread_id_i;
    end else if (hold_sel_s) begin
      result_valid_o = 1'b1;
      result_o       = WIDTH'(hold_q.result);
      trans_id_o     = hold_q.trans_id;
      thread_id_o    = hold_q.thread_id;
    end else begin
      result_valid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed, table-driven bench for muldiv_wb_arbiter.
module tb_muldiv_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, div_issue_i, div_word_op_i, div_valid_i, div_ready_o;
  logic [63:0] div_result_i, mul_result_i, result_o;
  logic [4:0]  div_trans_id_i, mul_trans_id_i, trans_id_o;
  logic [0:0]  div_thread_id_i, mul_thread_id_i, thread_id_o;
  logic        mul_valid_i, result_valid_o, div_busy_o;

  muldiv_wb_arbiter #(.WIDTH(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .div_issue_i(div_issue_i), .div_word_op_i(div_word_op_i),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_result_i(div_result_i), .div_trans_id_i(div_trans_id_i),
    .div_thread_id_i(div_thread_id_i),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .mul_trans_id_i(mul_trans_id_i), .mul_thread_id_i(mul_thread_id_i),
    .result_valid_o(result_valid_o), .result_o(result_o),
    .trans_id_o(trans_id_o), .thread_id_o(thread_id_o),
    .div_busy_o(div_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  ctl;   // {rst, flush, issue, word_op, div_valid}
    logic [63:0] dres;
    logic [4:0]  dtid;
    logic        dth;
    logic        mv;
    logic [63:0] mres;
    logic [4:0]  mtid;
    logic        mth;
    logic        ev;
    logic [63:0] eres;
    logic [4:0]  etid;
    logic        eth;
    logic        ebusy;
    logic        erdy;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [63:0] dres,
                              input logic [4:0] dtid, input logic dth,
                              input logic mv, input logic [63:0] mres,
                              input logic [4:0] mtid, input logic mth,
                              input logic ev, input logic [63:0] eres,
                              input logic [4:0] etid, input logic eth,
                              input logic ebusy, input logic erdy);
    vec_t v;
    v.ctl = ctl; v.dres = dres; v.dtid = dtid; v.dth = dth;
    v.mv = mv; v.mres = mres; v.mtid = mtid; v.mth = mth;
    v.ev = ev; v.eres = eres; v.etid = etid; v.eth = eth;
    v.ebusy = ebusy; v.erdy = erdy;
    return v;
  endfunction

  task automatic drive_idle();
    rst_i = 1'b0; flush_i = 1'b0; div_issue_i = 1'b0; div_word_op_i = 1'b0;
    div_valid_i = 1'b0; div_result_i = 64'd0; div_trans_id_i = 5'd0; div_thread_id_i = 1'b0;
    mul_valid_i = 1'b0; mul_result_i = 64'd0; mul_trans_id_i = 5'd0; mul_thread_id_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic found, blocked_bad;
    //            ctl       dres                    dtid  dth  mv    mres     mtid  mth  ev    eres                    etid  eth  busy  rdy
    vecs[0]  = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[1]  = mk(5'b00001, 64'h7,                  5'd3, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[2]  = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b1, 64'h7,                  5'd3, 1'b0,1'b1, 1'b1);
    vecs[3]  = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[4]  = mk(5'b00110, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[5]  = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b1, 1'b1);
    vecs[6]  = mk(5'b00001, 64'h0000_0000_8000_0000,5'd2, 1'b1,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b1, 1'b1);
    vecs[7]  = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b1, 64'hFFFF_FFFF_8000_0000,5'd2, 1'b1,1'b1, 1'b1);
    vecs[8]  = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[9]  = mk(5'b00100, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[10] = mk(5'b00001, 64'h1_2345_6789,        5'd5, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b1, 1'b1);
    vecs[11] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b1, 64'hA1,  5'd1, 1'b0,1'b1, 64'hA1,                 5'd1, 1'b0,1'b1, 1'b0);
    vecs[12] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b1, 64'hA2,  5'd2, 1'b0,1'b1, 64'hA2,                 5'd2, 1'b0,1'b1, 1'b0);
    vecs[13] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b1, 64'hA4,  5'd4, 1'b1,1'b1, 64'hA4,                 5'd4, 1'b1,1'b1, 1'b0);
    vecs[14] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b1, 64'h1_2345_6789,        5'd5, 1'b0,1'b1, 1'b1);
    vecs[15] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[16] = mk(5'b00001, 64'h50,                 5'd5, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[17] = mk(5'b00001, 64'h60,                 5'd6, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b1, 64'h50,                 5'd5, 1'b0,1'b1, 1'b1);
    vecs[18] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b1, 64'h60,                 5'd6, 1'b0,1'b1, 1'b1);
    vecs[19] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[20] = mk(5'b00100, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[21] = mk(5'b00001, 64'h70,                 5'd7, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b1, 1'b1);
    vecs[22] = mk(5'b01001, 64'h77,                 5'd8, 1'b0,1'b1, 64'h99,  5'd9, 1'b0,1'b1, 64'h99,                 5'd9, 1'b0,1'b1, 1'b1);
    vecs[23] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[24] = mk(5'b00100, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);
    vecs[25] = mk(5'b00001, 64'h33,                 5'd3, 1'b1,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b1, 1'b1);
    vecs[26] = mk(5'b10000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b1, 64'h33,                 5'd3, 1'b1,1'b1, 1'b1);
    vecs[27] = mk(5'b00000, 64'h0,                  5'd0, 1'b0,1'b0, 64'h0,   5'd0, 1'b0,1'b0, 64'h0,                  5'd0, 1'b0,1'b0, 1'b1);

    drive_idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Table: inputs applied just after an edge, outputs sampled on the falling edge.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i); #1;
      {rst_i, flush_i, div_issue_i, div_word_op_i, div_valid_i} = vecs[i].ctl;
      div_result_i = vecs[i].dres; div_trans_id_i = vecs[i].dtid; div_thread_id_i = vecs[i].dth;
      mul_valid_i = vecs[i].mv; mul_result_i = vecs[i].mres;
      mul_trans_id_i = vecs[i].mtid; mul_thread_id_i = vecs[i].mth;
      @(negedge clk_i);
      tests_run++;
      if (result_valid_o !== vecs[i].ev || result_o !== vecs[i].eres ||
          trans_id_o !== vecs[i].etid || thread_id_o !== vecs[i].eth ||
          div_busy_o !== vecs[i].ebusy || div_ready_o !== vecs[i].erdy) begin
        tests_failed++;
        $display("FAIL vec%0d: got v=%0b r=%h id=%0d th=%0d busy=%0b rdy=%0b, want v=%0b r=%h id=%0d th=%0d busy=%0b rdy=%0b",
                 i, result_valid_o, result_o, trans_id_o, thread_id_o, div_busy_o, div_ready_o,
                 vecs[i].ev, vecs[i].eres, vecs[i].etid, vecs[i].eth, vecs[i].ebusy, vecs[i].erdy);
      end
    end

    // Hand sequence: capture id 10, then a 4-cycle mul burst; drain must follow the burst.
    @(posedge clk_i); #1;
    drive_idle();
    div_valid_i = 1'b1; div_result_i = 64'hABC; div_trans_id_i = 5'd10;
    lat = 0; found = 1'b0; blocked_bad = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk_i); #1;
      div_valid_i = 1'b0;
      mul_valid_i = (k < 4);
      mul_result_i = 64'(k + 16);
      mul_trans_id_i = 5'(k + 1);
      @(negedge clk_i);
      lat++;
      if (result_valid_o && trans_id_o == 5'd10) begin
        found = 1'b1;
        tests_run++;
        if (result_o !== 64'hABC) begin
          tests_failed++;
          $display("FAIL burst_data: got %h want %h", result_o, 64'hABC);
        end
      end else if (k < 4 && div_ready_o !== 1'b0) begin
        blocked_bad = 1'b1;
      end
    end
    tests_run++;
    if (!found || lat != 5 || blocked_bad) begin
      tests_failed++;
      $display("FAIL burst_latency: got found=%0b lat=%0d ready_leak=%0b want found=1 lat=5 ready_leak=0",
               found, lat, blocked_bad);
    end

    @(posedge clk_i); #1;
    drive_idle();
    @(negedge clk_i);
    tests_run++;
    if (result_valid_o !== 1'b0 || div_busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_idle: got v=%0b busy=%0b want v=0 busy=0", result_valid_o, div_busy_o);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
